// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round sequencer and its neighbours.
// The slave side is the sequencer. The master side is the input buffer/consumer (or a bench).
interface aes_round_ctrl_if;
  logic       ld_i;
  logic       ack_i;
  logic       busy_o;
  logic       init_o;
  logic       kload_o;
  logic       round_en_o;
  logic       final_o;
  logic       kexp_en_o;
  logic [3:0] round_o;
  logic [7:0] rcon_o;
  logic       done_o;
  logic       ld_reject_o;

  modport slave (
    input  ld_i, ack_i,
    output busy_o, init_o, kload_o, round_en_o, final_o, kexp_en_o,
           round_o, rcon_o, done_o, ld_reject_o
  );

  modport master (
    output ld_i, ack_i,
    input  busy_o, init_o, kload_o, round_en_o, final_o, kexp_en_o,
           round_o, rcon_o, done_o, ld_reject_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: initial AddRoundKey, NUM_ROUNDS round enables with Rcon,
// final-round select, then done held until acknowledged. Every output is a flop.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic           clk,
  input  logic           rst,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t     state_q;
  logic [3:0] round_q;
  logic [7:0] rcon_q;
  logic       busy_q;
  logic       init_q;
  logic       ren_q;
  logic       final_q;
  logic       done_q;
  logic       rej_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      rcon_q  <= '0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      ren_q   <= 1'b0;
      final_q <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      init_q  <= 1'b0;
      ren_q   <= 1'b0;
      final_q <= 1'b0;
      rej_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ld_i) begin
            state_q <= S_INIT;
            init_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_INIT: begin
          state_q <= S_ROUND;
          round_q <= 4'd1;
          rcon_q  <= 8'h01;
          ren_q   <= 1'b1;
          rej_q   <= bus.ld_i;
        end
        S_ROUND: begin
          ren_q   <= 1'b1;
          round_q <= round_q + 4'd1;
          rcon_q  <= xtime(rcon_q);
          rej_q   <= bus.ld_i;
          if (round_q == LAST_ROUND) begin
            state_q <= S_FINAL;
            final_q <= 1'b1;
          end
        end
        S_FINAL: begin
          state_q <= S_DONE;
          round_q <= '0;
          rcon_q  <= '0;
          done_q  <= 1'b1;
          rej_q   <= bus.ld_i;
        end
        S_DONE: begin
          if (bus.ack_i) begin
            done_q <= 1'b0;
            if (bus.ld_i) begin
              state_q <= S_INIT;
              init_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            rej_q <= bus.ld_i;
          end
        end
        default: begin
          state_q <= S_IDLE;
          round_q <= '0;
          rcon_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.init_o      = init_q;
  assign bus.kload_o     = init_q;
  assign bus.round_en_o  = ren_q;
  assign bus.kexp_en_o   = ren_q;
  assign bus.final_o     = final_q;
  assign bus.round_o     = round_q;
  assign bus.rcon_o      = rcon_q;
  assign bus.done_o      = done_q;
  assign bus.ld_reject_o = rej_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the AES encryption round datapath. It sits between the 32-to-128-bit input buffer, whose ld pulse marks a full text/key block, and the round/key-expansion datapath.
- Per block it issues the initial AddRoundKey, then NUM_ROUNDS round enables with the matching Rcon, and the final-round select.
- It then holds done_o until the consumer acknowledges the result.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; legal values are 10, 12 and 14.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- ld_i  in  1  one-cycle pulse: text/key block valid at the datapath inputs
- ack_i  in  1  consumer has taken the result
- busy_o  out  1  controller not in IDLE
- init_o  out  1  datapath loads state = text ^ key this cycle
- kload_o  out  1  key schedule loads the cipher key this cycle
- round_en_o  out  1  state register takes the round-function output
- final_o  out  1  current round skips MixColumns
- kexp_en_o  out  1  key schedule advances one round key
- round_o  out  4  current round index
- rcon_o  out  8  round constant for round_o
- done_o  out  1  ciphertext valid, held until acknowledged
- ld_reject_o  out  1  one-cycle pulse: ld_i arrived while not accepting

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - All outputs are 0, including round_o=0 and rcon_o=0x00.
  - This applies mid-operation too: the current block is abandoned and no done_o is produced.
- States:
  - IDLE: all strobes 0.
    - ld_i=1 at an edge -> INIT.
  - INIT (1 cycle): init_o=1, kload_o=1, round_o=0, rcon_o=0x00.
    - -> ROUND with round=1.
  - ROUND: round_en_o=1, kexp_en_o=1, final_o=0, round_o=r, rcon_o=Rcon(r).
    - If r==NUM_ROUNDS-1 -> FINAL, else r increments and stays in ROUND.
  - FINAL (1 cycle): round_en_o=1, kexp_en_o=1, final_o=1, round_o=NUM_ROUNDS, rcon_o=Rcon(NUM_ROUNDS).
    - -> DONE.
  - DONE: done_o=1, all strobes 0, round_o=0, rcon_o=0x00.
    - ack_i=1 and ld_i=0 -> IDLE.
    - ack_i=1 and ld_i=1 -> INIT (back-to-back block, no IDLE bubble).
    - ack_i=0 -> stay in DONE.
- Rcon:
  - Rcon(1)=0x01 and Rcon(r+1)=xtime(Rcon(r)) in GF(2^8) modulo 0x11B.
  - NUM_ROUNDS=10 sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Rounds above 10 continue the xtime sequence: 6C, D8, AB, 4D.
  - Rcon is held in a register updated alongside the round counter; it is not a lookup ROM.
- busy_o = (state != IDLE).
- Strobes and round_o/rcon_o are Moore outputs decoded from the registered state and counters. They are glitch-free relative to the clk edge.
- Latency: ld_i is sampled at edge E0, and done_o rises NUM_ROUNDS+2 cycles after E0 (12 cycles for NUM_ROUNDS=10).
- Exactly one round_en_o per round, so NUM_ROUNDS round_en_o cycles per block; init_o and kload_o are high exactly once per block.
- ld_reject_o:
  - Registered pulse one cycle after an ld_i sampled in INIT, ROUND or FINAL.
  - Also pulsed for ld_i sampled in DONE with ack_i=0.
  - A rejected ld_i has no effect on state, round_o or rcon_o.
- Simultaneous ld_i and reset: reset wins, and no ld_reject_o is produced.
- The round counter never exceeds NUM_ROUNDS, and round_o=0 whenever the state is not ROUND/FINAL.

Test Plan:
- Reset release, idle 5 cycles -> all outputs 0; busy_o=0.
- Single ld_i pulse at E0, NUM_ROUNDS=10 ->
  - init_o and kload_o in cycle 1;
  - round_o 1..9 in cycles 2-10;
  - final_o in cycle 11 with round_o=10 and rcon_o=0x36;
  - done_o from cycle 12, held until ack_i.
- Check rcon_o per round -> 01,02,04,08,10,20,40,80,1B,36; NUM_ROUNDS=14 continues 6C,D8,AB,4D.
- ld_i at round 5, and ld_i in DONE without ack_i -> ld_reject_o one cycle later each; sequencing and round_o unaffected.
- ack_i and ld_i together in DONE -> next cycle INIT with init_o=1, no IDLE cycle; second block completes in the same 12 cycles.
- rst asserted asynchronously in ROUND (round_o=6) -> outputs 0 immediately; after release, IDLE with no done_o; a new ld_i runs a full block correctly.
